render_cmd_sequencer: RTL and testbench



---
 rtl/render_cmd_sequencer_if.sv | 46 ++++
 rtl/render_cmd_sequencer.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_render_cmd_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/render_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// render_cmd_sequencer_if
// Bus bundle for the render command sequencer.
//   slave_*  : CPU-facing register port (HPS bridge side).
//     slave_address[1:0], slave_read, slave_readdata[31:0],
//     slave_write, slave_writedata[31:0], slave_waitrequest
//   master_* : renderer-facing register port.
//     master_address[3:0], master_write, master_writedata[31:0],
//     master_read, master_readdata[31:0], master_waitrequest
// Modports are written from the sequencer's point of view:
//   slave  - the sequencer answers CPU accesses
//   master - the sequencer drives renderer accesses
// ---------------------------------------------------------------------------
interface render_cmd_sequencer_if;
  logic [1:0]  slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        slave_waitrequest;

  logic [3:0]  master_address;
  logic        master_write;
  logic [31:0] master_writedata;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_waitrequest;

  modport slave (
    input  slave_address,
    input  slave_read,
    input  slave_write,
    input  slave_writedata,
    output slave_readdata,
    output slave_waitrequest
  );

  modport master (
    output master_address,
    output master_write,
    output master_writedata,
    output master_read,
    input  master_readdata,
    input  master_waitrequest
  );
endinterface

// File: rtl/render_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// render_cmd_sequencer
// Command FIFO plus replay sequencer in front of the frame renderer slave.
// The CPU pushes packed draw commands without waiting; each command is
// replayed to the renderer as writes mid_x(1), mid_y(2), tex_code(4), go(6),
// optionally preceded by polling the frame-flip parity at address 5.
//
// Ports:
//   clk    : system clock
//   rst_n  : synchronous, active-low reset
//   cpu    : CPU register port (slave modport)
//            wr addr0 push command, addr2 bit0 flush / bit1 clear overflow,
//            addr3 bit0 enable; rd addr0 status, addr1 issued count
//   rnd    : renderer register port (master modport)
//
// Command word: [9:0] mid_x (signed), [18:10] mid_y (signed),
//               [25:19] tex_code, [26] sync, [31:27] ignored.
// ---------------------------------------------------------------------------
module render_cmd_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  render_cmd_sequencer_if.slave         cpu,
  render_cmd_sequencer_if.master        rnd
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SYNC0,
    S_SCAP0,
    S_SYNC,
    S_SCAP,
    S_WX,
    S_WY,
    S_WT,
    S_GO
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  // Renderer register map
  localparam logic [3:0] RA_MIDX  = 4'd1;
  localparam logic [3:0] RA_MIDY  = 4'd2;
  localparam logic [3:0] RA_TEX   = 4'd4;
  localparam logic [3:0] RA_FLIP  = 4'd5;
  localparam logic [3:0] RA_GO    = 4'd6;

  // ---------------------------------------------------------------------
  // Field extraction helpers
  // ---------------------------------------------------------------------
  function automatic logic [31:0] sext_x(input logic [9:0] v);
    logic signed [9:0]  x;
    logic signed [31:0] r;
    x = v;
    r = x;
    return r;
  endfunction

  function automatic logic [31:0] sext_y(input logic [8:0] v);
    logic signed [8:0]  y;
    logic signed [31:0] r;
    y = v;
    r = y;
    return r;
  endfunction

  function automatic logic [31:0] zext_tex(input logic [6:0] v);
    return {25'd0, v};
  endfunction

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic [26:0]  mem_q [DEPTH];
  logic [26:0]  hold_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          en_q, en_d;
  logic [31:0]   rdata_q, rdata_d;

  state_t        state_q;
  logic [3:0]    m_addr_q;
  logic          m_wr_q;
  logic          m_rd_q;
  logic [31:0]   m_wdata_q;
  logic          p0_q;
  logic [15:0]   issued_q;

  // ---------------------------------------------------------------------
  // CPU decode
  // ---------------------------------------------------------------------
  logic        push_req, push, pop, clr, ovf_clr, en_wr;
  logic        empty, full, busy;
  logic [26:0] head;
  logic [5:0]  count6;

  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_CNT);
  assign busy   = (state_q != S_IDLE);
  assign head   = mem_q[rd_ptr_q];
  assign count6 = 6'(count_q);

  assign push_req = cpu.slave_write && (cpu.slave_address == 2'd0);
  assign clr      = cpu.slave_write && (cpu.slave_address == 2'd2) && cpu.slave_writedata[0];
  assign ovf_clr  = cpu.slave_write && (cpu.slave_address == 2'd2) && cpu.slave_writedata[1];
  assign en_wr    = cpu.slave_write && (cpu.slave_address == 2'd3);

  // Full is judged on the current count: a same-cycle pop never makes room.
  // A flush takes priority over both push and pop.
  assign push = push_req && !full && !clr;
  assign pop  = (state_q == S_IDLE) && en_q && !empty && !clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + ONE_CNT;
      else if (!push && pop) count_d = count_q - ONE_CNT;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (push_req && full) ovf_d = 1'b1;
    else if (ovf_clr)     ovf_d = 1'b0;
  end

  assign en_d = en_wr ? cpu.slave_writedata[0] : en_q;

  always_comb begin
    rdata_d = 32'd0;
    if (cpu.slave_read) begin
      case (cpu.slave_address)
        2'd0:    rdata_d = {22'd0, ovf_q, busy, empty, full, count6};
        2'd1:    rdata_d = {16'd0, issued_q};
        default: rdata_d = 32'd0;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FIFO control and CPU-side registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      en_q     <= 1'b1;
      rdata_q  <= 32'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      en_q     <= en_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage and holding register carry data only; no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cpu.slave_writedata[26:0];
    if (pop)  hold_q <= head;
  end

  // ---------------------------------------------------------------------
  // Replay FSM: one renderer access per state, all bus outputs registered.
  // Address/data/strobe are loaded on entry to a state and held until the
  // renderer accepts (waitrequest low).
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      m_addr_q  <= 4'd0;
      m_wr_q    <= 1'b0;
      m_rd_q    <= 1'b0;
      m_wdata_q <= 32'd0;
      p0_q      <= 1'b0;
      issued_q  <= 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            if (head[26]) begin
              state_q  <= S_SYNC0;
              m_rd_q   <= 1'b1;
              m_addr_q <= RA_FLIP;
            end else begin
              state_q   <= S_WX;
              m_wr_q    <= 1'b1;
              m_addr_q  <= RA_MIDX;
              m_wdata_q <= sext_x(head[9:0]);
            end
          end
        end
        S_SYNC0: begin
          if (!rnd.master_waitrequest) begin
            state_q <= S_SCAP0;
            m_rd_q  <= 1'b0;
          end
        end
        S_SCAP0: begin
          // Read data arrives the cycle after the accept; it is the
          // reference parity that a later poll must differ from.
          p0_q    <= rnd.master_readdata[0];
          state_q <= S_SYNC;
          m_rd_q  <= 1'b1;
        end
        S_SYNC: begin
          if (!rnd.master_waitrequest) begin
            state_q <= S_SCAP;
            m_rd_q  <= 1'b0;
          end
        end
        S_SCAP: begin
          if (rnd.master_readdata[0] != p0_q) begin
            state_q   <= S_WX;
            m_wr_q    <= 1'b1;
            m_addr_q  <= RA_MIDX;
            m_wdata_q <= sext_x(hold_q[9:0]);
          end else begin
            state_q <= S_SYNC;
            m_rd_q  <= 1'b1;
          end
        end
        S_WX: begin
          if (!rnd.master_waitrequest) begin
            state_q   <= S_WY;
            m_addr_q  <= RA_MIDY;
            m_wdata_q <= sext_y(hold_q[18:10]);
          end
        end
        S_WY: begin
          if (!rnd.master_waitrequest) begin
            state_q   <= S_WT;
            m_addr_q  <= RA_TEX;
            m_wdata_q <= zext_tex(hold_q[25:19]);
          end
        end
        S_WT: begin
          if (!rnd.master_waitrequest) begin
            state_q   <= S_GO;
            m_addr_q  <= RA_GO;
            m_wdata_q <= 32'd0;
          end
        end
        S_GO: begin
          if (!rnd.master_waitrequest) begin
            state_q   <= S_IDLE;
            m_wr_q    <= 1'b0;
            m_addr_q  <= 4'd0;
            m_wdata_q <= 32'd0;
            issued_q  <= issued_q + 16'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          m_wr_q  <= 1'b0;
          m_rd_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign cpu.slave_readdata    = rdata_q;
  assign cpu.slave_waitrequest = 1'b0;

  assign rnd.master_address   = m_addr_q;
  assign rnd.master_write     = m_wr_q;
  assign rnd.master_read      = m_rd_q;
  assign rnd.master_writedata = m_wdata_q;

  logic unused_ok;
  assign unused_ok = ^{cpu.slave_writedata[31:27], rnd.master_readdata[31:1], hold_q[26]};

endmodule

// File: tb/tb_render_cmd_sequencer.sv
module tb_render_cmd_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  render_cmd_sequencer_if bus ();

  render_cmd_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cpu   (bus),
    .rnd   (bus)
  );

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
    int          rds;
    int          cyc;
  } wr_t;

  wr_t  wlog[$];
  int   cyc = 0;
  int   go_cnt = 0;
  int   rd_cnt = 0;
  int   bad_rd = 0;
  int   both_hi = 0;
  int   last_wr_edge = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [15:0] parity_bits = 16'd0;

  // Renderer model: readdata for the k-th accepted read is parity_bits[k],
  // presented during the cycle after the accept.
  assign bus.master_readdata = {31'd0, parity_bits[rd_cnt[3:0]]};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.master_write === 1'b1 && bus.master_waitrequest === 1'b0) begin
      wlog.push_back('{bus.master_address, bus.master_writedata, rd_cnt, cyc});
      if (bus.master_address == 4'd6) go_cnt <= go_cnt + 1;
    end
    if (bus.master_read === 1'b1 && bus.master_waitrequest === 1'b0) begin
      rd_cnt <= rd_cnt + 1;
      if (bus.master_address != 4'd5) bad_rd <= bad_rd + 1;
    end
    if (bus.master_read === 1'b1 && bus.master_write === 1'b1) both_hi <= both_hi + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.slave_write     = 1'b1;
    bus.slave_address   = a;
    bus.slave_writedata = d;
    last_wr_edge        = cyc;
    @(negedge clk);
    bus.slave_write     = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.slave_read    = 1'b1;
    bus.slave_address = a;
    @(negedge clk);
    bus.slave_read    = 1'b0;
    d = bus.slave_readdata;
  endtask

  task automatic wait_go(input int target, input int budget, input string tag);
    for (int k = 0; k < budget && go_cnt < target; k++) @(negedge clk);
    check(tag, 64'(go_cnt >= target), 64'd1);
  endtask

  // Waits at negedges until a write to address a is being presented.
  task automatic wait_wr_addr(input logic [3:0] a, input int budget, input string tag);
    for (int k = 0; k < budget && !(bus.master_write === 1'b1 && bus.master_address == a); k++)
      @(negedge clk);
    check(tag, {bus.master_write, bus.master_address}, {1'b1, a});
  endtask

  initial begin
    logic [31:0] rd;
    int base;
    int go0;

    bus.slave_address      = 2'd0;
    bus.slave_read         = 1'b0;
    bus.slave_write        = 1'b0;
    bus.slave_writedata    = 32'd0;
    bus.master_waitrequest = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {bus.master_write, bus.master_read, bus.master_address, bus.master_writedata,
           bus.slave_readdata, bus.slave_waitrequest}, 64'd0);
    rst_n = 1'b1;
    cpu_read(2'd0, rd);  check("reset_status", rd, 32'h0000_0080);
    cpu_read(2'd1, rd);  check("reset_issued", rd, 32'd0);
    cpu_read(2'd2, rd);  check("read_addr2_zero", rd, 32'd0);

    // One command: tex=2, y=30, x=80
    base = wlog.size();
    cpu_write(2'd0, 32'h0010_7850);
    wait_go(1, 50, "t1_go_timeout");
    check("t1_wx", {wlog[base+0].a, wlog[base+0].d}, {4'd1, 32'h50});
    check("t1_wy", {wlog[base+1].a, wlog[base+1].d}, {4'd2, 32'h1E});
    check("t1_wt", {wlog[base+2].a, wlog[base+2].d}, {4'd4, 32'h02});
    check("t1_go", {wlog[base+3].a, wlog[base+3].d}, {4'd6, 32'h00});
    // Push cycle through GO-accept cycle inclusive is six cycles: five edges apart.
    check("t1_latency", 64'(wlog[base+3].cyc - last_wr_edge), 64'd5);
    cpu_read(2'd1, rd);  check("t1_issued", rd, 32'd1);
    cpu_read(2'd0, rd);  check("t1_status", rd, 32'h0000_0080);

    // Negative coordinates: x=-5, y=-3
    base = wlog.size();
    cpu_write(2'd0, 32'h0007_F7FB);
    wait_go(2, 50, "t2_go_timeout");
    check("t2_midx", {wlog[base+0].a, wlog[base+0].d}, {4'd1, 32'hFFFF_FFFB});
    check("t2_midy", {wlog[base+1].a, wlog[base+1].d}, {4'd2, 32'hFFFF_FFFD});

    // Stall for 7 cycles during WY
    base = wlog.size();
    cpu_write(2'd0, 32'h0010_7850);
    wait_wr_addr(4'd2, 20, "t3_wy_seen");
    bus.master_waitrequest = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("t3_hold", {bus.master_write, bus.master_read, bus.master_address, bus.master_writedata},
            {1'b1, 1'b0, 4'd2, 32'h1E});
    end
    bus.master_waitrequest = 1'b0;
    wait_go(3, 50, "t3_go_timeout");
    check("t3_wy_after_stall", 64'(wlog[base+1].cyc - wlog[base+0].cyc), 64'd8);
    check("t3_wt_follows", 64'(wlog[base+2].cyc - wlog[base+1].cyc), 64'd1);
    check("t3_wt_data", {wlog[base+2].a, wlog[base+2].d}, {4'd4, 32'h02});

    // Overflow: 17 pushes while paused
    cpu_write(2'd3, 32'd0);
    for (int i = 0; i < 17; i++) cpu_write(2'd0, 32'(i + 1) | (32'(i) << 19));
    cpu_read(2'd0, rd);  check("t4_full_status", rd, 32'h0000_0250);
    check("t4_no_issue_paused", 64'(go_cnt), 64'd3);
    base = wlog.size();
    cpu_write(2'd3, 32'd1);
    wait_go(19, 400, "t4_go_timeout");
    repeat (20) @(negedge clk);
    check("t4_go_count", 64'(go_cnt), 64'd19);
    for (int i = 0; i < 16; i++) begin
      check("t4_order_x", {wlog[base+4*i].a, wlog[base+4*i].d}, {4'd1, 32'(i + 1)});
      check("t4_order_go", 64'(wlog[base+4*i+3].a), 64'd6);
    end
    cpu_read(2'd1, rd);  check("t4_issued", rd, 32'd19);
    cpu_write(2'd2, 32'h2);
    cpu_read(2'd0, rd);  check("t4_ovf_cleared", rd, 32'h0000_0080);

    // Sync command: parity 1,1,1,0
    parity_bits = 16'b0000_0000_0000_1110;
    base = wlog.size();
    cpu_write(2'd0, 32'h0410_7850);
    wait_go(20, 100, "t5_go_timeout");
    check("t5_read_count", 64'(rd_cnt), 64'd4);
    check("t5_reads_before_wx", 64'(wlog[base+0].rds), 64'd4);
    check("t5_wx", {wlog[base+0].a, wlog[base+0].d}, {4'd1, 32'h50});
    check("t5_read_addr", 64'(bad_rd), 64'd0);

    // Reset mid-transfer
    cpu_write(2'd0, 32'h0010_7850);
    wait_wr_addr(4'd2, 20, "t6_wy_seen");
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_strobes_drop", {bus.master_write, bus.master_read, bus.master_address}, 64'd0);
    rst_n = 1'b1;
    cpu_read(2'd0, rd);  check("t6_status", rd, 32'h0000_0080);
    cpu_read(2'd1, rd);  check("t6_issued", rd, 32'd0);

    // Flush while first of five is in WT
    cpu_write(2'd3, 32'd0);
    for (int i = 0; i < 5; i++) cpu_write(2'd0, 32'(16 + i));
    base = wlog.size();
    go0  = go_cnt;
    cpu_write(2'd3, 32'd1);
    wait_wr_addr(4'd4, 30, "t7_wt_seen");
    bus.master_waitrequest = 1'b1;
    cpu_write(2'd2, 32'h1);
    bus.master_waitrequest = 1'b0;
    wait_go(go0 + 1, 50, "t7_go_timeout");
    repeat (30) @(negedge clk);
    check("t7_one_go", 64'(go_cnt - go0), 64'd1);
    check("t7_wx", {wlog[base+0].a, wlog[base+0].d}, {4'd1, 32'd16});
    cpu_read(2'd1, rd);  check("t7_issued", rd, 32'd1);
    cpu_read(2'd0, rd);  check("t7_status", rd, 32'h0000_0080);

    check("never_both_strobes", 64'(both_hi), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
